// File: rtl/demux_1x4_reg.sv
// Registered 1-to-4 demultiplexer with a one-entry holding register per output
// channel and a saturating delivered-word counter per channel.
//
// Handshake: a word moves across an interface in any cycle where its valid and
// ready are both high at the rising edge. The upstream side (i_valid/o_ready)
// accepts one word for channel i_sel. Each downstream channel k (o_valid[k] /
// i_ready[k]) delivers its held word. o_ready depends only on the state and
// ready of the selected channel, never on i_valid. A valid word on a channel is
// held stable until it is taken.
//
// Each channel is a two-state EMPTY/FULL machine. Its state is o_valid[k], so
// every channel FSM is visible on the ports.
module demux_1x4_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DATA_WIDTH-1:0]   i_din,
  input  logic [1:0]              i_sel,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [DATA_WIDTH-1:0]   o_dout_00,
  output logic [DATA_WIDTH-1:0]   o_dout_01,
  output logic [DATA_WIDTH-1:0]   o_dout_10,
  output logic [DATA_WIDTH-1:0]   o_dout_11,
  output logic [3:0]              o_valid,
  input  logic [3:0]              i_ready,
  output logic [4*CNT_WIDTH-1:0]  o_cnt,
  output logic                    o_busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  chan_state_e           state_q [4];
  chan_state_e           state_d [4];
  logic [DATA_WIDTH-1:0] data_q  [4];
  logic [CNT_WIDTH-1:0]  cnt_q   [4];
  logic [3:0]            full;
  logic [3:0]            accept;
  logic [3:0]            deliver;

  // Decode channel FSM states into the per-channel full flags.
  always_comb begin
    full = '0;
    for (int k = 0; k < 4; k++) begin
      full[k] = (state_q[k] == FULL);
    end
  end

  assign o_valid = full;
  assign o_busy  = |full;
  assign deliver = full & i_ready;

  // Input side can take a word if the selected channel is empty or draining now.
  always_comb begin
    o_ready = ~full[i_sel] | i_ready[i_sel];
  end

  // One-hot accept strobe; i_sel is only looked at while i_valid is high.
  always_comb begin
    accept = '0;
    if (i_valid && o_ready) begin
      accept[i_sel] = 1'b1;
    end
  end

  // Channel next-state: a same-cycle deliver and accept keeps the channel full.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        EMPTY: if (accept[k])                 state_d[k] = FULL;
        FULL:  if (deliver[k] && !accept[k])  state_d[k] = EMPTY;
      endcase
    end
  end

  // Channel state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 4; k++) state_q[k] <= EMPTY;
    end else begin
      for (int k = 0; k < 4; k++) state_q[k] <= state_d[k];
    end
  end

  // Holding registers load only on accept and otherwise keep their last word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept[k]) data_q[k] <= i_din;
      end
    end
  end

  // Delivered-word counters, saturating at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (deliver[k] && (cnt_q[k] != CNT_MAX)) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  assign o_dout_00 = data_q[0];
  assign o_dout_01 = data_q[1];
  assign o_dout_10 = data_q[2];
  assign o_dout_11 = data_q[3];

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign o_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

endmodule

// File: tb/tb_demux_1x4_reg.sv
// Testbench for demux_1x4_reg. A second instance with a 2-bit counter shares
// all inputs so counter saturation can be seen after only a few deliveries.
module tb_demux_1x4_reg;

  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int CWS = 2;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   din;
  logic [1:0]      sel;
  logic            valid;
  logic [3:0]      rdy;

  logic            o_ready,  o_ready_s;
  logic [DW-1:0]   d0, d1, d2, d3;
  logic [DW-1:0]   s0, s1, s2, s3;
  logic [3:0]      vld, vld_s;
  logic [4*CW-1:0] cnt;
  logic [4*CWS-1:0] cnt_s;
  logic            busy, busy_s;

  always #5 clk = ~clk;

  demux_1x4_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_din(din), .i_sel(sel), .i_valid(valid),
    .o_ready(o_ready), .o_dout_00(d0), .o_dout_01(d1), .o_dout_10(d2), .o_dout_11(d3),
    .o_valid(vld), .i_ready(rdy), .o_cnt(cnt), .o_busy(busy)
  );

  demux_1x4_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CWS)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_din(din), .i_sel(sel), .i_valid(valid),
    .o_ready(o_ready_s), .o_dout_00(s0), .o_dout_01(s1), .o_dout_10(s2), .o_dout_11(s3),
    .o_valid(vld_s), .i_ready(rdy), .o_cnt(cnt_s), .o_busy(busy_s)
  );

  // ---------------- reference model ----------------
  // Each channel is a queue of held words (never more than one) plus the last
  // word it showed and an unbounded count of deliveries.
  logic [DW-1:0] m_hold [4][$];
  logic [DW-1:0] m_last [4];
  int            m_deliv [4];
  logic          exp_ready;
  logic          obs_ready;
  int            checks   = 0;
  int            failures = 0;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_hold[k].delete();
      m_last[k]  = '0;
      m_deliv[k] = 0;
    end
  endtask

  function automatic logic [3:0] exp_valid();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = (m_hold[k].size() != 0);
    return r;
  endfunction

  function automatic logic [CW-1:0] exp_cnt(input int k);
    int lim = (1 << CW) - 1;
    return (m_deliv[k] > lim) ? CW'(lim) : CW'(m_deliv[k]);
  endfunction

  function automatic logic [CWS-1:0] exp_cnt_s(input int k);
    int lim = (1 << CWS) - 1;
    return (m_deliv[k] > lim) ? CWS'(lim) : CWS'(m_deliv[k]);
  endfunction

  function automatic logic [CW-1:0] dut_cnt(input int k);
    return cnt[k*CW +: CW];
  endfunction

  function automatic logic [CWS-1:0] dut_cnt_s(input int k);
    return cnt_s[k*CWS +: CWS];
  endfunction

  function automatic logic [DW-1:0] dut_dout(input int k);
    case (k)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      default: return d3;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of inputs after the falling edge, samples o_ready before
  // the rising edge, advances the model at the edge, and returns 1 ns later.
  task automatic cycle(input logic [DW-1:0] d, input logic [1:0] s,
                       input logic v, input logic [3:0] r);
    @(negedge clk);
    din = d; sel = s; valid = v; rdy = r;
    #1;
    exp_ready = (m_hold[s].size() == 0) || r[s];
    obs_ready = o_ready;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (m_hold[k].size() != 0 && r[k]) begin
        void'(m_hold[k].pop_front());
        m_deliv[k]++;
      end
    end
    if (v && exp_ready) begin
      m_hold[s].push_back(d);
      m_last[s] = d;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (vld !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=0000", vld); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_dout(k) !== '0) begin
        failures++; $display("FAIL reset_dout ch=%0d got=%h exp=0", k, dut_dout(k));
      end
    end
  endtask

  task automatic test_cnt_saturation();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) cycle($urandom, 2'd3, 1'b1, 4'b1111);
      else       cycle('0, 2'd0, 1'b0, 4'b1111);
      checks++;
      if (dut_cnt_s(3) !== exp_cnt_s(3)) begin
        failures++; $display("FAIL sat_step i=%0d got=%0d exp=%0d", i, dut_cnt_s(3), exp_cnt_s(3));
      end
    end
    checks++;
    if (dut_cnt_s(3) !== 2'd3) begin failures++; $display("FAIL sat_final got=%0d exp=3", dut_cnt_s(3)); end
    checks++;
    if (dut_cnt(3) !== 8'd5) begin failures++; $display("FAIL sat_main got=%0d exp=5", dut_cnt(3)); end
  endtask

  task automatic test_single_route();
    logic [CW-1:0] base;
    base = exp_cnt(2);
    cycle(32'hDEADBEEF, 2'b10, 1'b1, 4'b1111);
    checks++;
    if (obs_ready !== 1'b1) begin failures++; $display("FAIL route_ready got=%b exp=1", obs_ready); end
    checks++;
    if (vld !== 4'b0100) begin failures++; $display("FAIL route_valid got=%b exp=0100", vld); end
    checks++;
    if (d2 !== 32'hDEADBEEF) begin failures++; $display("FAIL route_dout got=%h exp=deadbeef", d2); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL route_busy got=%b exp=1", busy); end
    cycle('0, 2'd0, 1'b0, 4'b1111);
    checks++;
    if (dut_cnt(2) !== base + 8'd1) begin
      failures++; $display("FAIL route_cnt got=%0d exp=%0d", dut_cnt(2), base + 8'd1);
    end
    checks++;
    if (vld !== 4'b0000) begin failures++; $display("FAIL route_drain got=%b exp=0000", vld); end
    checks++;
    if (d2 !== 32'hDEADBEEF) begin failures++; $display("FAIL route_hold got=%h exp=deadbeef", d2); end
  endtask

  task automatic test_backpressure();
    cycle(32'h11, 2'b01, 1'b1, 4'b1101);
    checks++;
    if (obs_ready !== 1'b1 || d1 !== 32'h11) begin
      failures++; $display("FAIL bp_first ready=%b dout=%h exp ready=1 dout=11", obs_ready, d1);
    end
    cycle(32'h22, 2'b01, 1'b1, 4'b1101);
    checks++;
    if (obs_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready got=%b exp=0", obs_ready); end
    checks++;
    if (d1 !== 32'h11 || vld[1] !== 1'b1) begin
      failures++; $display("FAIL bp_hold dout=%h valid=%b exp dout=11 valid=1", d1, vld[1]);
    end
    cycle(32'h22, 2'b01, 1'b1, 4'b1111);
    checks++;
    if (obs_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", obs_ready); end
    checks++;
    if (d1 !== 32'h22 || vld[1] !== 1'b1) begin
      failures++; $display("FAIL bp_reload dout=%h valid=%b exp dout=22 valid=1", d1, vld[1]);
    end
    checks++;
    if (dut_cnt(1) !== exp_cnt(1)) begin
      failures++; $display("FAIL bp_cnt got=%0d exp=%0d", dut_cnt(1), exp_cnt(1));
    end
    cycle('0, 2'd0, 1'b0, 4'b1111);
  endtask

  task automatic test_isolation();
    cycle(32'h77, 2'b01, 1'b1, 4'b0101);
    cycle(32'hA5, 2'b11, 1'b1, 4'b0101);
    checks++;
    if (obs_ready !== 1'b1) begin failures++; $display("FAIL iso_ready got=%b exp=1", obs_ready); end
    checks++;
    if (d3 !== 32'hA5 || vld[3] !== 1'b1) begin
      failures++; $display("FAIL iso_dout dout=%h valid=%b exp dout=a5 valid=1", d3, vld[3]);
    end
    checks++;
    if (d1 !== 32'h77 || vld[1] !== 1'b1) begin
      failures++; $display("FAIL iso_other dout=%h valid=%b exp dout=77 valid=1", d1, vld[1]);
    end
    cycle('0, 2'd0, 1'b0, 4'b1111);
    cycle('0, 2'd0, 1'b0, 4'b1111);
    checks++;
    if (vld !== 4'b0000) begin failures++; $display("FAIL iso_drain got=%b exp=0000", vld); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w;
    logic [CW-1:0] base;
    base = exp_cnt(0);
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      cycle(w, 2'b00, 1'b1, 4'b1111);
      checks++;
      if (obs_ready !== 1'b1 || d0 !== w || vld[0] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_word i=%0d ready=%b dout=%h valid=%b exp ready=1 dout=%h valid=1",
                 i, obs_ready, d0, vld[0], w);
      end
    end
    cycle('0, 2'd0, 1'b0, 4'b1111);
    checks++;
    if (dut_cnt(0) !== base + 8'd8) begin
      failures++; $display("FAIL b2b_cnt got=%0d exp=%0d", dut_cnt(0), base + 8'd8);
    end
  endtask

  task automatic test_main_saturation();
    for (int i = 0; i < 262; i++) begin
      cycle($urandom, 2'b01, 1'b1, 4'b1111);
      checks++;
      if (dut_cnt(1) !== exp_cnt(1)) begin
        failures++; $display("FAIL msat_step i=%0d got=%0d exp=%0d", i, dut_cnt(1), exp_cnt(1));
      end
    end
    cycle('0, 2'd0, 1'b0, 4'b1111);
    checks++;
    if (dut_cnt(1) !== 8'hFF) begin failures++; $display("FAIL msat_final got=%0d exp=255", dut_cnt(1)); end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       v;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = 4'($urandom);
      cycle($urandom, 2'($urandom_range(0, 3)), v, r);
      checks++;
      if (obs_ready !== exp_ready) begin
        failures++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, obs_ready, exp_ready);
      end
      checks++;
      if (vld !== exp_valid()) begin
        failures++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, vld, exp_valid());
      end
      checks++;
      if (busy !== |exp_valid()) begin
        failures++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, busy, |exp_valid());
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dut_dout(k) !== m_last[k]) begin
          failures++; $display("FAIL rand_dout i=%0d ch=%0d got=%h exp=%h", i, k, dut_dout(k), m_last[k]);
        end
        checks++;
        if (dut_cnt(k) !== exp_cnt(k) || dut_cnt_s(k) !== exp_cnt_s(k)) begin
          failures++;
          $display("FAIL rand_cnt i=%0d ch=%0d got=%0d/%0d exp=%0d/%0d",
                   i, k, dut_cnt(k), dut_cnt_s(k), exp_cnt(k), exp_cnt_s(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) cycle($urandom | 32'h1, 2'(k), 1'b1, 4'b0000);
    checks++;
    if (vld !== 4'b1111) begin failures++; $display("FAIL rmid_fill got=%b exp=1111", vld); end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (vld !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL rmid_valid valid=%b busy=%b exp 0000/0", vld, busy);
    end
    checks++;
    if (cnt !== '0 || cnt_s !== '0) begin
      failures++; $display("FAIL rmid_cnt got=%h/%h exp=0", cnt, cnt_s);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_dout(k) !== '0) begin
        failures++; $display("FAIL rmid_dout ch=%0d got=%h exp=0", k, dut_dout(k));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(32'hCAFE0001, 2'b00, 1'b1, 4'b1111);
    checks++;
    if (d0 !== 32'hCAFE0001 || vld !== 4'b0001) begin
      failures++; $display("FAIL rmid_resume dout=%h valid=%b exp cafe0001/0001", d0, vld);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; din = '0; sel = '0; valid = 1'b0; rdy = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_cnt_saturation();
    test_single_route();
    test_backpressure();
    test_isolation();
    test_back_to_back();
    test_main_saturation();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
